// File: rtl/midi_parser.sv
// MIDI byte-stream decoder: running status, real-time passthrough, SysEx skip,
// note on/off events one cycle after the completing byte, monophonic gate tracking.
module midi_parser #(
  parameter bit         OMNI    = 1'b1,
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       note_on,
  output logic       note_off,
  output logic [3:0] channel,
  output logic [6:0] note,
  output logic [6:0] velocity,
  output logic       gate,
  output logic [6:0] held_note,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} state_t;

  state_t     state;
  logic [3:0] rs_type;
  logic [3:0] rs_chan;
  logic [6:0] d1;
  logic       accept;
  logic       one_byte_msg;

  assign accept       = OMNI || (rs_chan == CHANNEL);
  assign one_byte_msg = (rs_type == 4'hC) || (rs_type == 4'hD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rs_type   <= 4'd0;
      rs_chan   <= 4'd0;
      d1        <= 7'd0;
      note_on   <= 1'b0;
      note_off  <= 1'b0;
      err       <= 1'b0;
      channel   <= 4'd0;
      note      <= 7'd0;
      velocity  <= 7'd0;
      gate      <= 1'b0;
      held_note <= 7'd0;
    end else begin
      note_on  <= 1'b0;
      note_off <= 1'b0;
      err      <= 1'b0;
      if (data_valid) begin
        if (data >= 8'hF8) begin
          // real-time bytes may appear anywhere and never disturb parsing
        end else if (data[7]) begin
          if (data < 8'hF0) begin
            rs_type <= data[7:4];
            rs_chan <= data[3:0];
            state   <= WAIT_D1;
          end else if (data == 8'hF0) begin
            state <= SYSEX;
          end else begin
            state <= IDLE;
          end
        end else begin
          case (state)
            IDLE:    err <= 1'b1;
            WAIT_D1: begin
              d1    <= data[6:0];
              state <= one_byte_msg ? WAIT_D1 : WAIT_D2;
            end
            WAIT_D2: begin
              state <= WAIT_D1;
              if (accept && (rs_type == 4'h8 || rs_type == 4'h9)) begin
                channel  <= rs_chan;
                note     <= d1;
                velocity <= data[6:0];
                if (rs_type == 4'h9 && data[6:0] != 7'd0) begin
                  note_on   <= 1'b1;
                  gate      <= 1'b1;
                  held_note <= d1;
                end else begin
                  note_off <= 1'b1;
                  if (d1 == held_note) gate <= 1'b0;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_parser.sv
// Randomized + directed scoreboard bench for midi_parser (OMNI and channel-1 instances).
module tb_midi_parser;

  localparam int HALF = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       data_valid;

  logic       on0, off0, err0, gate0;
  logic [3:0] ch0;
  logic [6:0] note0, vel0, held0;
  logic       on1, off1, err1, gate1;
  logic [3:0] ch1;
  logic [6:0] note1, vel1, held1;

  int tests = 0;
  int fails = 0;

  always #HALF clk = ~clk;

  midi_parser dut0 (
    .clk(clk), .rst(rst), .data(data), .data_valid(data_valid),
    .note_on(on0), .note_off(off0), .channel(ch0), .note(note0),
    .velocity(vel0), .gate(gate0), .held_note(held0), .err(err0)
  );

  midi_parser #(.OMNI(1'b0), .CHANNEL(4'd1)) dut1 (
    .clk(clk), .rst(rst), .data(data), .data_valid(data_valid),
    .note_on(on1), .note_off(off1), .channel(ch1), .note(note1),
    .velocity(vel1), .gate(gate1), .held_note(held1), .err(err1)
  );

  // {on,off,err, channel, note, velocity, gate, held_note}
  typedef struct packed {
    logic [28:0] v;
    logic [63:0] due;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  // Reference model: message-level view (status byte + collected data bytes)
  logic [7:0] m_rs[2];
  logic       m_sx[2];
  int         m_nd[2];
  logic [6:0] m_msg[2][2];
  logic [3:0] m_ch[2];
  logic [6:0] m_note[2], m_vel[2], m_held[2];
  logic       m_gate[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_rs[k] = 8'h00; m_sx[k] = 1'b0; m_nd[k] = 0;
      m_ch[k] = 4'd0; m_note[k] = 7'd0; m_vel[k] = 7'd0;
      m_held[k] = 7'd0; m_gate[k] = 1'b0;
    end
  endtask

  task automatic push(input int k, input logic [2:0] kind);
    ev_t e;
    e.v   = {kind, m_ch[k], m_note[k], m_vel[k], m_gate[k], m_held[k]};
    e.due = $time + HALF;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic model_byte(input int k, input logic [7:0] b);
    int  need;
    logic [3:0] typ;
    logic [3:0] chn;
    if (b >= 8'hF8) return;
    if (b[7]) begin
      m_nd[k] = 0;
      if (b < 8'hF0) begin
        m_rs[k] = b; m_sx[k] = 1'b0;
      end else begin
        m_rs[k] = 8'h00; m_sx[k] = (b == 8'hF0);
      end
      return;
    end
    if (m_rs[k] == 8'h00) begin
      if (!m_sx[k]) push(k, 3'b001);
      return;
    end
    typ  = m_rs[k][7:4];
    chn  = m_rs[k][3:0];
    need = (typ == 4'hC || typ == 4'hD) ? 1 : 2;
    m_msg[k][m_nd[k]] = b[6:0];
    m_nd[k]++;
    if (m_nd[k] < need) return;
    m_nd[k] = 0;
    if (need != 2 || (typ != 4'h8 && typ != 4'h9)) return;
    if (k == 1 && chn != 4'd1) return;
    m_ch[k] = chn; m_note[k] = m_msg[k][0]; m_vel[k] = m_msg[k][1];
    if (typ == 4'h9 && m_msg[k][1] != 7'd0) begin
      m_gate[k] = 1'b1; m_held[k] = m_msg[k][0];
      push(k, 3'b100);
    end else begin
      if (m_msg[k][0] == m_held[k]) m_gate[k] = 1'b0;
      push(k, 3'b010);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_event(input string name, input logic [28:0] act, ref ev_t q[$]);
    ev_t e;
    tests++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL %s unexpected event at %0t: got %h", name, $time, act);
    end else begin
      e = q.pop_front();
      if (act !== e.v || $time != e.due) begin
        fails++;
        $display("FAIL %s event: got %h at %0t expected %h at %0t", name, act, $time, e.v, e.due);
      end
    end
  endtask

  always @(negedge clk) begin
    if (on0 || off0 || err0)
      check_event("dut0", {on0, off0, err0, ch0, note0, vel0, gate0, held0}, q0);
    if (on1 || off1 || err1)
      check_event("dut1", {on1, off1, err1, ch1, note1, vel1, gate1, held1}, q1);
  end

  task automatic send(input logic [7:0] b);
    data = b; data_valid = 1'b1;
    @(posedge clk);
    model_byte(0, b);
    model_byte(1, b);
    #1 data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle(2);
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    #1 rst = 1'b0;
    #(HALF);
    chk("rst_out0", {on0, off0, err0, ch0, note0, vel0, gate0, held0}, 32'd0);
    chk("rst_out1", {on1, off1, err1, ch1, note1, vel1, gate1, held1}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_list(input logic [7:0] bs[$]);
    foreach (bs[i]) begin
      send(bs[i]);
      idle($urandom_range(0, 2));
    end
    idle(2);
  endtask

  initial begin
    logic [7:0] b;
    int r;
    rst = 1'b1; data = 8'h00; data_valid = 1'b0;
    model_reset();
    idle(1);
    do_reset();

    send_list('{8'h90, 8'h3C, 8'h64});
    chk("t1_gate", {31'd0, gate0}, 32'd1);
    chk("t1_held", {25'd0, held0}, 32'h3C);
    send_list('{8'h90, 8'h3C, 8'h64, 8'h40, 8'h50});
    chk("t2_held", {25'd0, held0}, 32'h40);
    send_list('{8'h3C, 8'h00});
    chk("t2_gate", {31'd0, gate0}, 32'd1);
    send_list('{8'h80, 8'h40, 8'h10});
    chk("t3_gate", {31'd0, gate0}, 32'd0);
    chk("t3_held", {25'd0, held0}, 32'h40);
    chk("t3_vel", {25'd0, vel0}, 32'h10);
    send_list('{8'h90, 8'h3C, 8'hF8, 8'h64});
    chk("t4_note", {25'd0, note0}, 32'h3C);

    do_reset();
    send_list('{8'h3C, 8'hF0, 8'h01, 8'h02, 8'hF7, 8'h3C, 8'hC0, 8'h05});
    send_list('{8'h90, 8'h3C, 8'h64, 8'h91, 8'h3C, 8'h64});
    chk("t6_ch1", {28'd0, ch1}, 32'd1);
    chk("t6_gate1", {31'd0, gate1}, 32'd1);
    send_list('{8'h91, 8'h3C});
    do_reset();
    send_list('{8'h64});

    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      b = 8'($urandom_range(0, 127));
      else if (r < 75) b = {3'b100, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 2))};
      else if (r < 85) b = 8'($urandom_range(8'hA0, 8'hEF));
      else if (r < 89) b = 8'hF0;
      else if (r < 93) b = 8'hF7;
      else if (r < 96) b = 8'($urandom_range(8'hF1, 8'hF6));
      else             b = 8'($urandom_range(8'hF8, 8'hFF));
      // small note range makes matching note-offs likely
      if (r < 45 && $urandom_range(0, 1) == 1) b = 8'($urandom_range(8'h3C, 8'h3F));
      if (r < 45 && $urandom_range(0, 7) == 0) b = 8'h00;
      send(b);
      idle($urandom_range(0, 2));
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    idle(4);
    chk("q0_empty", q0.size(), 32'd0);
    chk("q1_empty", q1.size(), 32'd0);
    chk("end_state0", {ch0, note0, vel0, gate0, held0}, {m_ch[0], m_note[0], m_vel[0], m_gate[0], m_held[0]});
    chk("end_state1", {ch1, note1, vel1, gate1, held1}, {m_ch[1], m_note[1], m_vel[1], m_gate[1], m_held[1]});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
